// File: rtl/mem_port_responder_if.sv
// -----------------------------------------------------------------------------
// mem_port_responder_if
// Purpose : bundles the two requester ports and the responder's return path
//           between the control unit and mem_port_responder.
// Signals : mem_read1/mem_write1/addr1/wr_data1 - port-1 request (level)
//           mem_read2/mem_write2/addr2/wr_data2 - port-2 request (level)
//           rd_data1/rd_data2                   - read data per port
//           ack1/ack2                           - one-cycle completion pulses
//           busy                                - responder not idle
// Modports: master = requester side, slave = responder side.
// -----------------------------------------------------------------------------
interface mem_port_responder_if;
    logic        mem_read1;
    logic        mem_write1;
    logic [15:0] addr1;
    logic [15:0] wr_data1;
    logic        mem_read2;
    logic        mem_write2;
    logic [15:0] addr2;
    logic [15:0] wr_data2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        ack1;
    logic        ack2;
    logic        busy;

    modport master (
        output mem_read1, mem_write1, addr1, wr_data1,
        output mem_read2, mem_write2, addr2, wr_data2,
        input  rd_data1, rd_data2, ack1, ack2, busy
    );

    modport slave (
        input  mem_read1, mem_write1, addr1, wr_data1,
        input  mem_read2, mem_write2, addr2, wr_data2,
        output rd_data1, rd_data2, ack1, ack2, busy
    );
endinterface

// File: rtl/mem_port_responder.sv
// -----------------------------------------------------------------------------
// mem_port_responder
// Purpose : serves two request ports onto one single-ported 16-bit word RAM.
//           Round-robin arbitration on ties, programmable wait states, a
//           one-cycle Ack per access and a mandatory ACK->IDLE bubble.
// Ports   : clk     - system clock, rising edge
//           rst     - asynchronous active-high reset
//           port_if - slave side of mem_port_responder_if (requests in,
//                     read data / acks / busy out)
// Params  : ADDR_W      - RAM address bits (depth 2**ADDR_W)
//           WAIT_STATES - extra cycles between grant and Ack (0..15)
// -----------------------------------------------------------------------------
module mem_port_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_responder_if.slave  port_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [3:0] WS_C    = 4'(WAIT_STATES);

    logic [15:0]       mem_q [0:(2**ADDR_W)-1];

    logic [1:0]        state_q,   state_d;
    logic [3:0]        cnt_q,     cnt_d;
    logic              port2_q,   port2_d;   // granted port: 1 = port 2
    logic              wr_q,      wr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [15:0]       wdata_q,   wdata_d;
    logic              last2_q,   last2_d;   // last served port: 1 = port 2
    logic [15:0]       rd_data1_q, rd_data1_d;
    logic [15:0]       rd_data2_q, rd_data2_d;
    logic              ack1_q,    ack1_d;
    logic              ack2_q,    ack2_d;
    logic              busy_q,    busy_d;

    logic              pend1_s;
    logic              pend2_s;
    logic              sel2_s;
    logic [15:0]       rd_word_s;
    logic              unused_addr_s;

    // Upper address bits are deliberately dropped (address aliasing).
    assign unused_addr_s = ^{port_if.addr1, port_if.addr2};

    // Request decode and round-robin port selection.
    always_comb begin
        pend1_s = port_if.mem_read1 | port_if.mem_write1;
        pend2_s = port_if.mem_read2 | port_if.mem_write2;
        if (pend1_s && pend2_s) begin
            sel2_s = ~last2_q;
        end else if (pend2_s) begin
            sel2_s = 1'b1;
        end else begin
            sel2_s = 1'b0;
        end
    end

    // FSM next state and grant latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port2_d = port2_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last2_d = last2_q;
        case (state_q)
            ST_IDLE: begin
                if (pend1_s || pend2_s) begin
                    port2_d = sel2_s;
                    last2_d = sel2_s;
                    // Write takes precedence when both strobes are high.
                    wr_d    = sel2_s ? port_if.mem_write2 : port_if.mem_write1;
                    addr_d  = sel2_s ? port_if.addr2[ADDR_W-1:0]
                                     : port_if.addr1[ADDR_W-1:0];
                    wdata_d = sel2_s ? port_if.wr_data2 : port_if.wr_data1;
                    if (WS_C == 4'd0) begin
                        state_d = ST_ACK;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q >= WS_C) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output next values; read data is captured on the edge entering ACK.
    always_comb begin
        rd_word_s = mem_q[addr_d];
        ack1_d    = (state_d == ST_ACK) && !port2_d;
        ack2_d    = (state_d == ST_ACK) &&  port2_d;
        busy_d    = (state_d != ST_IDLE);
        if ((state_d == ST_ACK) && (state_q != ST_ACK) && !wr_d) begin
            rd_data1_d = port2_d ? rd_data1_q : rd_word_s;
            rd_data2_d = port2_d ? rd_word_s  : rd_data2_q;
        end else begin
            rd_data1_d = rd_data1_q;
            rd_data2_d = rd_data2_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            port2_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            last2_q    <= 1'b1;     // port 1 wins the first tie
            rd_data1_q <= 16'h0000;
            rd_data2_q <= 16'h0000;
            ack1_q     <= 1'b0;
            ack2_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port2_q    <= port2_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last2_q    <= last2_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            ack1_q     <= ack1_d;
            ack2_q     <= ack2_d;
            busy_q     <= busy_d;
        end
    end

    // RAM write commits on the edge leaving ACK; reset forces IDLE so an
    // aborted write never reaches this point.
    always_ff @(posedge clk) begin
        if ((state_q == ST_ACK) && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign port_if.rd_data1 = rd_data1_q;
    assign port_if.rd_data2 = rd_data2_q;
    assign port_if.ack1     = ack1_q;
    assign port_if.ack2     = ack2_q;
    assign port_if.busy     = busy_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_port_responder
// Directed bench: dut A uses WAIT_STATES=1, dut B uses WAIT_STATES=0.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_responder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   lat;

    mem_port_responder_if bus_a ();
    mem_port_responder_if bus_b ();

    mem_port_responder #(.ADDR_W(10), .WAIT_STATES(1)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .port_if (bus_a)
    );

    mem_port_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .port_if (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input int p, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd);
        if (d == 0) begin
            if (p == 1) begin
                bus_a.mem_read1 = rd; bus_a.mem_write1 = wr; bus_a.addr1 = a; bus_a.wr_data1 = wd;
            end else begin
                bus_a.mem_read2 = rd; bus_a.mem_write2 = wr; bus_a.addr2 = a; bus_a.wr_data2 = wd;
            end
        end else begin
            if (p == 1) begin
                bus_b.mem_read1 = rd; bus_b.mem_write1 = wr; bus_b.addr1 = a; bus_b.wr_data1 = wd;
            end else begin
                bus_b.mem_read2 = rd; bus_b.mem_write2 = wr; bus_b.addr2 = a; bus_b.wr_data2 = wd;
            end
        end
    endtask

    function automatic logic get_ack(input int d, input int p);
        if (d == 0) return (p == 1) ? bus_a.ack1 : bus_a.ack2;
        else        return (p == 1) ? bus_b.ack1 : bus_b.ack2;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic [15:0] get_rd(input int d, input int p);
        if (d == 0) return (p == 1) ? bus_a.rd_data1 : bus_a.rd_data2;
        else        return (p == 1) ? bus_b.rd_data1 : bus_b.rd_data2;
    endfunction

    // One complete access; called on a falling edge, returns cycles to Ack.
    task automatic access(input int d, input int p, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        set_req(d, p, rd, wr, a, wd);
        for (int i = 1; i <= 32 && !done; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_after_grant", 32'(get_busy(d)), 32'd1);
            if (get_ack(d, p)) begin
                cyc  = i;
                done = 1'b1;
                check("busy_during_ack", 32'(get_busy(d)), 32'd1);
            end
        end
        if (!done) check("ack_timeout", 32'd0, 32'd1);
        set_req(d, p, 1'b0, 1'b0, a, wd);
        @(negedge clk);
        check("ack_one_cycle", 32'(get_ack(d, p)), 32'd0);
        check("busy_idle", 32'(get_busy(d)), 32'd0);
    endtask

    // Wait for either ack on dut A, bounded.
    task automatic wait_ack_a();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            if (bus_a.ack1 || bus_a.ack2) done = 1'b1;
        end
        if (!done) check("tie_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        set_req(0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(0, 2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1, 2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("rst_rd1", 32'(bus_a.rd_data1), 32'h0);
        check("rst_rd2", 32'(bus_a.rd_data2), 32'h0);
        check("rst_ack1", 32'(bus_a.ack1), 32'd0);
        check("rst_ack2", 32'(bus_a.ack2), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read latency with WAIT_STATES=1 (known word written first).
        access(0, 2, 1'b0, 1'b1, 16'h0005, 16'h5A5A, lat);
        check("wr2_lat", 32'(lat), 32'd2);
        check("wr2_rd2_unchanged", 32'(bus_a.rd_data2), 32'h0);
        access(0, 1, 1'b1, 1'b0, 16'h0005, 16'h0000, lat);
        check("rd1_lat", 32'(lat), 32'd2);
        check("rd1_data", 32'(bus_a.rd_data1), 32'h5A5A);
        check("rd1_rd2_unchanged", 32'(bus_a.rd_data2), 32'h0);

        // Write port 1, read back via port 2.
        access(0, 1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
        check("wr1_rd1_unchanged", 32'(bus_a.rd_data1), 32'h5A5A);
        access(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        check("rd2_beef", 32'(bus_a.rd_data2), 32'hBEEF);
        check("rd2_rd1_unchanged", 32'(bus_a.rd_data1), 32'h5A5A);

        // Address wrap above ADDR_W bits.
        access(0, 2, 1'b0, 1'b1, 16'h0403, 16'h1234, lat);
        access(0, 1, 1'b1, 1'b0, 16'h0003, 16'h0000, lat);
        check("wrap_read", 32'(bus_a.rd_data1), 32'h1234);

        // Reset during WAIT aborts an in-flight write.
        access(0, 1, 1'b0, 1'b1, 16'h0020, 16'h1111, lat);
        set_req(0, 1, 1'b0, 1'b1, 16'h0020, 16'hAAAA);
        @(negedge clk);
        check("abort_busy_wait", 32'(bus_a.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rd1", 32'(bus_a.rd_data1), 32'h0);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_ack1", 32'(bus_a.ack1), 32'd0);
        set_req(0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(0, 1, 1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        check("abort_not_committed", 32'(bus_a.rd_data1), 32'h1111);

        // Tie arbitration after reset: port 1 first, then port 2 wins the
        // re-tie because port 1 was served last.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1, 1'b1, 1'b0, 16'h0005, 16'h0000);
        set_req(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_ack_a();
        check("tie1_ack1", 32'(bus_a.ack1), 32'd1);
        check("tie1_ack2", 32'(bus_a.ack2), 32'd0);
        check("tie1_rd1", 32'(bus_a.rd_data1), 32'h5A5A);
        wait_ack_a();
        check("tie2_ack2", 32'(bus_a.ack2), 32'd1);
        check("tie2_ack1", 32'(bus_a.ack1), 32'd0);
        check("tie2_rd2", 32'(bus_a.rd_data2), 32'hBEEF);
        set_req(0, 2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_ack_a();
        check("tie3_ack1", 32'(bus_a.ack1), 32'd1);
        set_req(0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);

        // WAIT_STATES=0: back-to-back reads ack every second cycle.
        access(1, 1, 1'b0, 1'b1, 16'h0007, 16'h0707, lat);
        check("b_wr_lat", 32'(lat), 32'd1);
        set_req(1, 1, 1'b1, 1'b0, 16'h0007, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ack_%0d", i), 32'(bus_b.ack1), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        set_req(1, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("b2b_data", 32'(bus_b.rd_data1), 32'h0707);
        @(negedge clk);
        // Read and write together: write wins, read data untouched.
        access(1, 1, 1'b1, 1'b1, 16'h0007, 16'h7777, lat);
        check("rw_lat", 32'(lat), 32'd1);
        check("rw_rd1_unchanged", 32'(bus_b.rd_data1), 32'h0707);
        access(1, 2, 1'b1, 1'b0, 16'h0007, 16'h0000, lat);
        check("rw_written", 32'(bus_b.rd_data2), 32'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
